// File: rtl/mult_unit.sv
// Sequential shift-and-add multiplier: signed/unsigned/mixed operands, full 2*WIDTH-bit product.
// Latency: out_valid rises WIDTH+1 cycles after the acceptance edge (MULT_EARLY_TERM_EN: fewer when |b| is small).
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready; flush aborts CALC or DONE.
//
// Optional feature macro: MULT_EARLY_TERM_EN -- leave CALC once the remaining multiplier bits are all zero.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   op[1:0]               10 s*s, 01 u*u, 11 s(a)*u(b), 00 invalid (consumed, no result)
//   a, b [WIDTH-1:0]      operands, sampled only on the acceptance edge
//   in_valid / in_ready   request handshake
//   flush                 abort any in-flight operation; blocks acceptance in IDLE
//   c [2*WIDTH-1:0]       product, holds its last value until the next result is loaded
//   out_valid / out_ready result handshake
//   busy                  high whenever the FSM is not IDLE
module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [2*WIDTH-1:0]   c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic                 sign_q, sign_d;
    logic [2*WIDTH-1:0]   c_q, c_d;

    logic                 accept;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 calc_last;

    // a is signed for op 10 and 11, b only for op 10. The W-bit negation of
    // the most-negative value yields 2^(W-1), which is the correct unsigned
    // magnitude, so no extra bit is needed.
    assign a_neg  = op[1] & a[WIDTH-1];
    assign b_neg  = (op == 2'b10) & b[WIDTH-1];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;
    assign accept = (state_q == IDLE) & in_valid & ~flush;

    // calc_last marks the extra CALC cycle that only finalises the product.
`ifdef MULT_EARLY_TERM_EN
    // cnt_q != 0 enforces at least one shift-and-add cycle.
    assign calc_last = (cnt_q == CW'(WIDTH)) || ((cnt_q != '0) && (mplier_q == '0));
`else
    assign calc_last = (cnt_q == CW'(WIDTH));
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sign_d   = sign_q;
        c_d      = c_q;
        case (state_q)
            IDLE: begin
                // op 00 is consumed by the handshake but starts nothing.
                if (accept && (op != 2'b00)) begin
                    acc_d    = '0;
                    cnt_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    sign_d   = a_neg ^ b_neg;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (calc_last) begin
                    c_d     = sign_q ? -acc_q : acc_q;
                    state_d = DONE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (flush || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            c_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sign_q   <= sign_d;
            c_q      <= c_d;
        end
    end

    assign c         = c_q;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult_unit.sv
module tb_mult_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    // 32-bit instance
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [63:0] c;
    // 8-bit instance for the sweep
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic        iv8, ir8, fl8, ov8, or8, busy8;
    logic [15:0] c8;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mult_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .c(c), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    mult_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .op(op8), .a(a8), .b(b8),
        .in_valid(iv8), .in_ready(ir8), .flush(fl8),
        .c(c8), .out_valid(ov8), .out_ready(or8), .busy(busy8)
    );

    // Expected cycles from acceptance edge to out_valid for a multiplier magnitude.
    function automatic int exp_lat(input logic [63:0] mag, input int w);
`ifdef MULT_EARLY_TERM_EN
        int hb;
        hb = 0;
        for (int i = 0; i < w; i++) if (mag[i]) hb = i + 1;
        if (hb == 0) hb = 1;
        return hb + 1;
`else
        return w + 1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request on the 32-bit unit; scramble operands afterwards.
    task automatic start32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    // Wait (bounded) for out_valid; lat = 0 on timeout.
    task automatic wait_ov(output int lat);
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            if (i > 1 || 1'b1) tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [63:0] res, output int lat);
        start32(o, x, y);
        wait_ov(lat);
        res = c;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Watch n cycles; returns 1 if out_valid or busy was ever seen high.
    task automatic watch_quiet(input int n, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (out_valid || busy) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        total_cnt++; if (c !== 64'd0) $display("FAIL reset_c: got %h want 0", c); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_products();
        logic [63:0] r;
        int lat;
        run32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
        total_cnt++; if (r !== 64'hFFFF_FFFE_0000_0001) $display("FAIL uu_max: got %h want FFFFFFFE00000001", r); else pass_cnt++;
        total_cnt++; if (lat !== 33) $display("FAIL uu_max_latency: got %0d want 33", lat); else pass_cnt++;
        run32(2'b10, 32'h8000_0000, 32'h8000_0000, r, lat);
        total_cnt++; if (r !== 64'h4000_0000_0000_0000) $display("FAIL ss_minneg: got %h want 4000000000000000", r); else pass_cnt++;
        total_cnt++; if (lat !== 33) $display("FAIL ss_minneg_latency: got %0d want 33", lat); else pass_cnt++;
        run32(2'b10, 32'hFFFF_FFFD, 32'd7, r, lat);
        total_cnt++; if (r !== 64'hFFFF_FFFF_FFFF_FFEB) $display("FAIL ss_m3x7: got %h want FFFFFFFFFFFFFFEB", r); else pass_cnt++;
        total_cnt++; if (lat !== exp_lat(64'd7, 32)) $display("FAIL ss_m3x7_latency: got %0d want %0d", lat, exp_lat(64'd7, 32)); else pass_cnt++;
        run32(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
        total_cnt++; if (r !== 64'hFFFF_FFFF_0000_0001) $display("FAIL su_m1xmax: got %h want FFFFFFFF00000001", r); else pass_cnt++;
        run32(2'b10, 32'd9, 32'hFFFF_FFFE, r, lat);
        total_cnt++; if (r !== 64'hFFFF_FFFF_FFFF_FFEE) $display("FAIL ss_9xm2: got %h want FFFFFFFFFFFFFFEE", r); else pass_cnt++;
    endtask

    task automatic test_invalid_op();
        logic seen;
        start32(2'b00, 32'd3, 32'd4);
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL invop_in_ready: got %b want 1", in_ready); else pass_cnt++;
        watch_quiet(40, seen);
        total_cnt++; if (seen !== 1'b0) $display("FAIL invop_quiet: activity seen %b want 0", seen); else pass_cnt++;
    endtask

    task automatic test_hold_back_to_back();
        int lat;
        start32(2'b01, 32'd5, 32'd9);
        wait_ov(lat);
        total_cnt++; if (lat !== 33) $display("FAIL hold_latency: got %0d want 33", lat); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            tick();
            total_cnt++;
            if ({out_valid, c} !== {1'b1, 64'd45}) $display("FAIL hold_stable cycle %0d: got %b/%h want 1/2d", i, out_valid, c);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total_cnt++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL release_idle: got rdy/vld %b%b want 10", in_ready, out_valid); else pass_cnt++;
        start32(2'b01, 32'd2, 32'd3);
        total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_accept: busy %b want 1", busy); else pass_cnt++;
        wait_ov(lat);
        total_cnt++; if (c !== 64'd6) $display("FAIL b2b_result: got %h want 6", c); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic seen;
        logic [63:0] r;
        int lat;
        start32(2'b01, 32'h1234, 32'd5);
        for (int i = 0; i < 5; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total_cnt++; if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL flush_calc: got rdy/vld/busy %b%b%b want 100", in_ready, out_valid, busy); else pass_cnt++;
        watch_quiet(40, seen);
        total_cnt++; if (seen !== 1'b0) $display("FAIL flush_calc_quiet: activity %b want 0", seen); else pass_cnt++;
        run32(2'b01, 32'd6, 32'd7, r, lat);
        total_cnt++; if (r !== 64'd42) $display("FAIL after_flush_6x7: got %h want 2a", r); else pass_cnt++;
        // flush in IDLE wins over a valid request
        op = 2'b01; a = 32'd3; b = 32'd3; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        watch_quiet(40, seen);
        total_cnt++; if (seen !== 1'b0) $display("FAIL flush_idle_priority: activity %b want 0", seen); else pass_cnt++;
        // flush in DONE drops the result, c keeps it
        start32(2'b01, 32'd3, 32'd4);
        wait_ov(lat);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total_cnt++; if ({out_valid, in_ready, c} !== {2'b01, 64'd12}) $display("FAIL flush_done: got vld/rdy/c %b%b/%h want 01/c", out_valid, in_ready, c); else pass_cnt++;
    endtask

    task automatic test_reset_mid_calc();
        logic seen;
        start32(2'b10, 32'hFFFF_0001, 32'h0001_FFFF);
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        tick();
        total_cnt++; if ({c, out_valid, busy, in_ready} !== {64'd0, 3'b001}) $display("FAIL reset_mid_calc: got c/vld/busy/rdy %h/%b%b%b want 0/001", c, out_valid, busy, in_ready); else pass_cnt++;
        rst_n = 1'b1;
        watch_quiet(40, seen);
        total_cnt++; if (seen !== 1'b0) $display("FAIL reset_mid_calc_quiet: activity %b want 0", seen); else pass_cnt++;
    endtask

    task automatic test_latency();
        logic [63:0] r;
        int lat;
        run32(2'b01, 32'd5, 32'd0, r, lat);
        total_cnt++; if ({r, lat} !== {64'd0, exp_lat(64'd0, 32)}) $display("FAIL lat_b0: got %h/%0d want 0/%0d", r, lat, exp_lat(64'd0, 32)); else pass_cnt++;
        run32(2'b01, 32'd5, 32'd1, r, lat);
        total_cnt++; if ({r, lat} !== {64'd5, exp_lat(64'd1, 32)}) $display("FAIL lat_b1: got %h/%0d want 5/%0d", r, lat, exp_lat(64'd1, 32)); else pass_cnt++;
        run32(2'b01, 32'd3, 32'h8000_0000, r, lat);
        total_cnt++; if ({r, lat} !== {64'h1_8000_0000, 33}) $display("FAIL lat_bmsb: got %h/%0d want 180000000/33", r, lat); else pass_cnt++;
    endtask

    task automatic test_sweep8();
        logic [7:0] vals [12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h7F, 8'h80,
                                  8'h81, 8'hFE, 8'hFF, 8'h55, 8'hAA, 8'h10};
        logic [1:0] ops [3] = '{2'b01, 2'b10, 2'b11};
        longint sa, sb, p;
        logic [15:0] expv;
        logic [7:0] bm;
        int lat, elat, errs;
        errs = 0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 12; i++) begin
                for (int j = 0; j < 12; j++) begin
                    sa = ops[k][1] ? longint'($signed(vals[i])) : longint'(vals[i]);
                    sb = (ops[k] == 2'b10) ? longint'($signed(vals[j])) : longint'(vals[j]);
                    p = sa * sb;
                    expv = p[15:0];
                    bm = ((ops[k] == 2'b10) && vals[j][7]) ? 8'(-vals[j]) : vals[j];
                    elat = exp_lat({56'd0, bm}, 8);
                    op8 = ops[k]; a8 = vals[i]; b8 = vals[j]; iv8 = 1'b1;
                    tick();
                    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
                    lat = 0;
                    for (int t = 1; t <= 30; t++) begin
                        tick();
                        if (ov8) begin
                            lat = t;
                            break;
                        end
                    end
                    total_cnt++;
                    if ({c8, lat} !== {expv, elat}) begin
                        errs++;
                        if (errs <= 10)
                            $display("FAIL sweep8 op=%b a=%h b=%h: got %h/%0d want %h/%0d", ops[k], vals[i], vals[j], c8, lat, expv, elat);
                    end else pass_cnt++;
                    or8 = 1'b1;
                    tick();
                    or8 = 1'b0;
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; op = 2'b00; a = '0; b = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op8 = 2'b00; a8 = '0; b8 = '0; iv8 = 1'b0; fl8 = 1'b0; or8 = 1'b0;
        test_reset();
        test_products();
        test_invalid_op();
        test_hold_back_to_back();
        test_flush();
        test_reset_mid_calc();
        test_latency();
        test_sweep8();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal range 4..64.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port op, input, 2, operation: 2'b10 signed x signed, 2'b01 unsigned x unsigned, 2'b11 signed a x unsigned b, 2'b00 invalid.
REQ-005 SHALL have ports a and b, input, WIDTH each, operands sampled on acceptance.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the request handshake.
REQ-007 SHALL have port flush, input, 1, abort of any in-flight operation.
REQ-008 SHALL have port c, output, 2*WIDTH, full-width product.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the result handshake.
REQ-010 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-011 SHALL implement an FSM with states IDLE, CALC and DONE, with in_ready = 1 only in IDLE and out_valid = 1 only in DONE.
REQ-012 SHALL accept a request on a rising edge where in_valid and in_ready are both 1 and flush is 0.
REQ-013 SHALL, on acceptance with op = 2'b00, consume the request, stay in IDLE and produce no result.
REQ-014 SHALL, on acceptance with a valid op, register |a| and |b| as unsigned magnitudes, register sign = (a signed ? a[W-1] : 0) XOR (b signed ? b[W-1] : 0), clear the accumulator and enter CALC.
REQ-015 SHALL treat the most-negative operand, e.g. 32'h8000_0000, as magnitude 2^(WIDTH-1) without overflow.
REQ-016 SHALL, in CALC, process one multiplier bit per cycle by shift-and-add into a 2*WIDTH accumulator, using an iteration counter of $clog2(WIDTH+1) bits.
REQ-017 SHALL, after WIDTH CALC cycles, load c with sign ? two's-complement negation of the accumulator : the accumulator, and enter DONE, so that out_valid rises WIDTH+1 cycles after the acceptance edge.
REQ-018 SHALL hold c and out_valid stable in DONE until out_ready = 1, then return to IDLE on that edge; a new request is accepted no earlier than the following cycle.
REQ-019 SHALL, when flush = 1 in CALC or DONE, return to IDLE on that edge, drop out_valid and discard the result; c retains its last value.
REQ-020 SHALL, when flush = 1 in IDLE, give flush priority, so that no request is accepted in that cycle.
REQ-021 SHALL ignore changes on op, a and b outside the acceptance edge.
REQ-022 SHALL produce mathematically exact products for all operand and op combinations; no truncation or saturation.

Reset
REQ-023 SHALL, when rst_n = 0 at a rising edge, enter IDLE and clear the counter, accumulator and sign, setting c = 0, out_valid = 0, busy = 0 and in_ready = 1 after that edge.
REQ-024 SHALL let reset override flush and any handshake, including mid-CALC and in DONE, with no result emitted afterwards.

Configuration
REQ-025 SHALL, with macro MULT_EARLY_TERM_EN defined, leave CALC as soon as all unprocessed multiplier-magnitude bits are zero, with a minimum of one CALC cycle; b = 0 then gives out_valid two cycles after acceptance.
REQ-026 SHALL, without MULT_EARLY_TERM_EN, use a fixed CALC length of WIDTH cycles regardless of operands; results are identical in both builds.

Verification (WIDTH=32 unless noted)
REQ-027 SHALL cover: op=01, a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> c=64'hFFFF_FFFE_0000_0001, with out_valid exactly 33 cycles after acceptance (macro off).
REQ-028 SHALL cover: op=10, a=32'h8000_0000, b=32'h8000_0000 -> c=64'h4000_0000_0000_0000; op=10, a=-3, b=7 -> c=-21 (64'hFFFF_FFFF_FFFF_FFEB).
REQ-029 SHALL cover: op=11, a=-1, b=32'hFFFF_FFFF -> c=64'hFFFF_FFFF_0000_0001; op=00 with in_valid -> in_ready stays 1 and out_valid never rises.
REQ-030 SHALL cover: a result held with out_ready=0 for 10 cycles -> c and out_valid stable; out_ready=1 -> IDLE next cycle and a back-to-back request accepted one cycle later.
REQ-031 SHALL cover: flush asserted 5 cycles into CALC -> IDLE next cycle with no out_valid, after which 6x7 returns 42; rst_n=0 mid-CALC -> all outputs at reset values.
REQ-032 SHALL cover, with MULT_EARLY_TERM_EN defined: b=0 -> out_valid 2 cycles after acceptance; b=1 -> 2 cycles; b=32'h8000_0000 -> 33 cycles; also run the WIDTH=8 exhaustive sweep over all ops against a reference model.
